// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, id type and pointer-wrap helper for the adder share arbiter
package adder_arb_pkg;

    localparam int ADDER_WIDTH = 64;
    localparam int PERF_CNT_W  = 32;
    localparam int MAX_ID_W    = 4;

    typedef logic [MAX_ID_W-1:0] adder_id_t;

    // Next requester index after idx, wrapping back to 0 at num.
    function automatic adder_id_t idx_wrap(input adder_id_t idx, input int num);
        adder_id_t nxt;
        if (int'(idx) >= num - 1) begin
            nxt = '0;
        end else begin
            nxt = adder_id_t'(int'(idx) + 1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/adder_arb_rr.sv
// rtl/adder_arb_rr.sv - round-robin grant selection and pointer register for the shared adder
module adder_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    import adder_arb_pkg::*;

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] cand_idx;
    logic            found;
    int              cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        ptr_d     = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (accept_en && !found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
            ptr_d            = ID_W'(idx_wrap(adder_id_t'(grant_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_sklansky_64u.sv
// rtl/adder_sklansky_64u.sv - 64-bit unsigned Sklansky parallel-prefix adder, purely combinational
module adder_sklansky_64u (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] prop;
    logic [63:0] gp;
    logic [63:0] pp;
    logic [63:0] carry;
    int          j;

    always_comb begin
        prop  = a ^ b;
        gp    = a & b;
        pp    = prop;
        j     = 0;
        // Level l merges each bit with the top of the preceding 2^l-aligned block;
        // that partner bit is never rewritten on the same level, so in-place update is safe.
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < 64; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j     = ((i >> l) << l) - 1;
                    gp[i] = gp[i] | (pp[i] & gp[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        carry = {gp[62:0] | (pp[62:0] & {63{cin}}), cin};
        sum   = prop ^ carry;
        cout  = gp[63] | (pp[63] & cin);
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one 64-bit prefix adder behind a two-stage pipeline
// Optional per-requester grant and stall counters are built when ADDER_ARB_PERF_EN is defined.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = ADDER_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout
`ifdef ADDER_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
    output logic [PERF_CNT_W-1:0]         perf_stall_cnt
`endif
);

    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;

    logic               s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic [WIDTH-1:0]   s2_sum_q, s2_sum_d;
    logic               s2_cout_q, s2_cout_d;

    logic               s2_free;
    logic               s1_adv;
    logic               accept_en;
    logic               hs;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    assign s2_free   = !s2_valid_q || rsp_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    // Gating with rst keeps req_ready low for the whole reset cycle.
    assign accept_en = (!s1_valid_q || s2_free) && !rst;
    assign hs        = |(req_valid & grant);
    assign req_ready = grant;

    adder_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .accept_en (accept_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    adder_sklansky_64u u_adder (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (hs) begin
            s1_valid_d = 1'b1;
            s1_id_d    = grant_idx;
            s1_a_d     = req_a[grant_idx*WIDTH +: WIDTH];
            s1_b_d     = req_b[grant_idx*WIDTH +: WIDTH];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_sum_d   = s2_sum_q;
        s2_cout_d  = s2_cout_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_id_d    = s1_id_q;
            s2_sum_d   = add_sum;
            s2_cout_d  = add_cout;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_sum_q   <= s2_sum_d;
            s2_cout_q  <= s2_cout_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_sum   = s2_sum_q;
    assign rsp_cout  = s2_cout_q;

`ifdef ADDER_ARB_PERF_EN
    logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_q, perf_grant_d;
    logic [PERF_CNT_W-1:0]         perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs && grant[i]) begin
                perf_grant_d[i*PERF_CNT_W +: PERF_CNT_W] =
                    perf_grant_q[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
            end
        end
        if (s2_valid_q && !rsp_ready) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_cnt = perf_grant_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
`ifdef ADDER_ARB_PERF_EN
    logic [N*32-1:0] perf_grant_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int          errors;
    int          checks;
    int          cyc;

    int          m_ptr;
    bit          m_mid_v;
    int          m_mid_id;
    logic [64:0] m_mid_res;
    bit          m_out_v;
    int          m_out_id;
    logic [64:0] m_out_res;
`ifdef ADDER_ARB_PERF_EN
    int unsigned m_grant_cnt [N];
    int unsigned m_stall_cnt;
`endif

    int          hs_log[$];
    int          rsp_id_log[$];
    logic [63:0] rsp_sum_log[$];
    int          rsp_cyc_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_ptr     = 0;
        m_mid_v   = 0;
        m_mid_id  = 0;
        m_mid_res = '0;
        m_out_v   = 0;
        m_out_id  = 0;
        m_out_res = '0;
`ifdef ADDER_ARB_PERF_EN
        for (int i = 0; i < N; i++) m_grant_cnt[i] = 0;
        m_stall_cnt = 0;
`endif
    endtask

    // Compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        int          g;
        bit          adv;
        logic [N-1:0] exp_ready;
        logic [64:0] res;
        @(negedge clk);
        g   = -1;
        res = '0;
        if (!rst && (!m_mid_v || !m_out_v || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, m_out_v);
        chk("rsp_id", rsp_id, m_out_id);
        chk("rsp_sum", rsp_sum, m_out_res[63:0]);
        chk("rsp_cout", rsp_cout, m_out_res[64]);
`ifdef ADDER_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("perf_grant_cnt", perf_grant_cnt[i*32 +: 32], m_grant_cnt[i]);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
        if (|(req_valid & req_ready)) begin
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) hs_log.push_back(i);
        end
        if (rsp_valid && rsp_ready && !rst) begin
            rsp_id_log.push_back(int'(rsp_id));
            rsp_sum_log.push_back(rsp_sum);
            rsp_cyc_log.push_back(cyc);
        end
        if (g >= 0) res = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            adv = m_mid_v && (!m_out_v || rsp_ready);
`ifdef ADDER_ARB_PERF_EN
            if (m_out_v && !rsp_ready) m_stall_cnt++;
            if (g >= 0) m_grant_cnt[g]++;
`endif
            if (adv) begin
                m_out_v   = 1;
                m_out_id  = m_mid_id;
                m_out_res = m_mid_res;
            end else if (rsp_ready) begin
                m_out_v = 0;
            end
            if (g >= 0) begin
                m_mid_v   = 1;
                m_mid_id  = g;
                m_mid_res = res;
                m_ptr     = (g + 1) % N;
            end else if (adv) begin
                m_mid_v = 0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        model_clear();
        @(posedge clk);
        #1;

        // Reset, then idle
        tick();
        tick();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_sum", rsp_sum, 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_req_ready", req_ready, 4'b0000);

        // Single request with full carry-out
        req_a[0 +: W] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[0 +: W] = 64'd1;
        req_valid     = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_id", rsp_id, 2'd0);
        chk("single_sum", rsp_sum, 64'd0);
        chk("single_cout", rsp_cout, 1'b1);
        tick();

        // Fairness from a freshly reset pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = {$urandom, $urandom};
            req_b[i*W +: W] = {$urandom, $urandom};
        end
        hs_log.delete();
        rsp_id_log.delete();
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("fair_hs_count", hs_log.size(), 8);
        chk("fair_rsp_count", rsp_id_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < hs_log.size()) chk("fair_grant", hs_log[k], k % 4);
            if (k < rsp_id_log.size()) chk("fair_rsp_id", rsp_id_log[k], k % 4);
        end

        // Backpressure: two handshakes fill the pipe, then everything blocks
        hs_log.delete();
        rsp_ready = 1'b0;
        req_a[0 +: W] = 64'd100;  req_b[0 +: W] = 64'd23;
        req_a[W +: W] = 64'h8000_0000_0000_0000;  req_b[W +: W] = 64'h8000_0000_0000_0001;
        req_valid = 4'b0111;
        repeat (5) tick();
        chk("bp_handshakes", hs_log.size(), 2);
        chk("bp_ready_blocked", req_ready, 4'b0000);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        rsp_id_log.delete();
        rsp_sum_log.delete();
        rsp_ready = 1'b1;
        repeat (4) tick();
        chk("bp_drain_count", rsp_id_log.size(), 2);
        if (rsp_id_log.size() == 2) begin
            chk("bp_drain_id0", rsp_id_log[0], 0);
            chk("bp_drain_id1", rsp_id_log[1], 1);
            chk("bp_drain_sum0", rsp_sum_log[0], 64'd123);
            chk("bp_drain_sum1", rsp_sum_log[1], 64'd1);
        end

        // Throughput: one requester, one result per cycle
        rsp_id_log.delete();
        rsp_sum_log.delete();
        rsp_cyc_log.delete();
        req_valid = 4'b0100;
        for (int i = 1; i <= 16; i++) begin
            req_a[2*W +: W] = 64'(i);
            req_b[2*W +: W] = 64'(2 * i);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        chk("tp_count", rsp_sum_log.size(), 16);
        if (rsp_sum_log.size() == 16) begin
            chk("tp_span", rsp_cyc_log[15] - rsp_cyc_log[0], 15);
            for (int k = 0; k < 16; k++) begin
                chk("tp_sum", rsp_sum_log[k], 64'(3 * (k + 1)));
                chk("tp_id", rsp_id_log[k], 2);
            end
        end

        // Mid-operation reset with both stages full and stalled
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (4) tick();
        chk("full_rsp_valid", rsp_valid, 1'b1);
        chk("full_req_ready", req_ready, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_rsp_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b1;
        #1;
        chk("mr_first_grant", req_ready, 4'b0001);
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
